dsp_out_stage: RTL and testbench
================================

DSP_OUT_STAGE -- requirements
Module: dsp_out_stage

Interface
REQ-001 SHALL have parameter DSP_LAT, default 4: cycles from the upstream multiplier's operand sample to a valid p.
REQ-002 SHALL have parameter SHIFT, default 17: right-shift applied to p, range 0..47.
REQ-003 SHALL have parameter OUT_W, default 18: output word width, range 2..47.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries, power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: operands presented to the multiplier this cycle are a real sample.
REQ-008 SHALL have port p, input, signed 48 bits: multiplier/accumulator result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts out_data this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-011 SHALL have port out_data, output, signed OUT_W bits: rounded, saturated result.
REQ-012 SHALL have port out_sat, output, 1 bit: the current out_data word was saturated.
REQ-013 SHALL have port drop, output, 1 bit: one-cycle pulse when a word is lost because the FIFO is full.
REQ-014 SHALL have port sat_cnt, output, 16 bits: count of saturated words written, sticking at 0xFFFF.

Function
REQ-015 SHALL delay in_valid through a DSP_LAT-deep shift register; the tap output qualifies p on that cycle.
REQ-016 SHALL register round(p) in stage R1 when the tap is high: p + 2^(SHIFT-1), then arithmetic shift right by SHIFT; SHIFT=0 means no rounding add.
  - Width: 49-bit signed intermediate; the add never wraps.
REQ-017 SHALL saturate the R1 value to [-2^(OUT_W-1), 2^(OUT_W-1)-1] in stage R2 and set a per-word sat bit.
REQ-018 SHALL write {sat, data} to the FIFO at R2.
REQ-019 SHALL make out_valid first rise exactly DSP_LAT+2 cycles after in_valid was sampled, when the FIFO is empty.
REQ-020 SHALL use valid/ready handshake: a word transfers on an edge where out_valid and out_ready are both high.
  - out_data and out_sat hold stable while out_valid is high and out_ready is low.
REQ-021 SHALL never stall upstream (the multiplier has no backpressure).
  - On an R2 write to a full FIFO with no simultaneous read, the word is discarded and drop pulses for 1 cycle.
REQ-022 SHALL accept a simultaneous write and read on a full FIFO: no drop, occupancy unchanged.
REQ-023 SHALL accept a simultaneous write and read on an empty FIFO: the write is stored and out_valid rises next cycle; no bypass path.
REQ-024 SHALL increment sat_cnt only for saturated words actually stored, never for dropped ones; sat_cnt saturates at 0xFFFF with no wrap.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and use an extra bit to distinguish full from empty.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear the valid shift register, R1/R2 valid bits, FIFO pointers, out_valid, out_sat, drop and sat_cnt; out_data resets to 0.
REQ-027 SHALL discard in-flight samples and stored words on reset asserted mid-operation; the first output after release comes from an in_valid sampled after release.
REQ-028 SHALL leave data-path registers without reset apart from the output word.

Structure
REQ-029 SHALL take the DSP_P_W=48 constant and the saturate/round helper functions from the shared package dsp_pkg.
REQ-030 SHALL implement the buffer as sub-module sync_fifo (parameters WIDTH, DEPTH; asynchronous active-low reset).

Verification
REQ-031 SHALL cover basic latency (SHIFT=17, OUT_W=18): p=393216 (3<<17) with tap high -> out_data=3, out_sat=0, out_valid rises DSP_LAT+2 cycles after in_valid.
REQ-032 SHALL cover rounding: p=(5<<17)+(1<<16) -> 6; p=-(1<<16) -> 0; p=-(1<<16)-1 -> -1.
REQ-033 SHALL cover saturation: p=2^40 -> 131071 with out_sat=1; p=-2^40 -> -131072 with out_sat=1; sat_cnt=2.
REQ-034 SHALL cover backpressure: out_ready=0 and 5 consecutive valid samples -> 4 stored, drop pulses once on the 5th; raising out_ready drains 4 words in order.
REQ-035 SHALL cover full-FIFO write plus read: FIFO full, out_ready=1 and a new sample arrive together -> no drop, occupancy stays 4.
REQ-036 SHALL cover reset mid-stream: rst_n low for 1 cycle with 3 samples in flight and 2 stored -> out_valid=0 and sat_cnt=0 immediately, no stale word emitted afterwards.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants and fixed-point helpers for the DSP48 output path.
// All helpers work on a 49-bit signed value so rounding of a full 48-bit p cannot overflow.
package dsp_pkg;

    localparam int DSP_P_W = 48;

    // Round half up, then arithmetic shift right.
    function automatic logic signed [DSP_P_W:0] round_shift(
        input logic signed [DSP_P_W-1:0] p,
        input int                        shift
    );
        logic signed [DSP_P_W:0] ext;
        ext = {p[DSP_P_W-1], p};
        if (shift > 0)
            ext = ext + ({{DSP_P_W{1'b0}}, 1'b1} << (shift - 1));
        return ext >>> shift;
    endfunction

    function automatic logic signed [DSP_P_W:0] sat_max(input int out_w);
        logic signed [DSP_P_W:0] one;
        one = {{DSP_P_W{1'b0}}, 1'b1};
        return (one <<< (out_w - 1)) - one;
    endfunction

    // The most negative representable value is the bitwise inverse of the maximum.
    function automatic logic sat_hit(
        input logic signed [DSP_P_W:0] v,
        input int                      out_w
    );
        return (v > sat_max(out_w)) || (v < ~sat_max(out_w));
    endfunction

    function automatic logic signed [DSP_P_W:0] saturate(
        input logic signed [DSP_P_W:0] v,
        input int                      out_w
    );
        if (v > sat_max(out_w))
            return sat_max(out_w);
        else if (v < ~sat_max(out_w))
            return ~sat_max(out_w);
        else
            return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty and a combinational head read.
// A write into a full FIFO is accepted only when a read frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             wr_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_rd;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || do_rd);
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + (AW+1)'(1);
            if (do_rd)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dsp_out_stage.sv
// Multiplier output stage: qualify p with a delayed in_valid, round, saturate and buffer
// the result behind a valid/ready port; words that find the buffer full are dropped.
module dsp_out_stage
    import dsp_pkg::*;
#(
    parameter int DSP_LAT    = 4,
    parameter int SHIFT      = 17,
    parameter int OUT_W      = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [DSP_P_W-1:0] p,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic                      drop,
    output logic [15:0]               sat_cnt
);
    logic [DSP_LAT-1:0]      vld_sr;
    logic                    r1_valid;
    logic                    r2_valid;
    logic signed [DSP_P_W:0] r1_val;
    logic signed [OUT_W-1:0] r2_data;
    logic                    r2_sat;
    logic [OUT_W:0]          fifo_q;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
        end else begin
            vld_sr[0] <= in_valid;
            for (int i = 1; i < DSP_LAT; i++)
                vld_sr[i] <= vld_sr[i-1];
            r1_valid <= vld_sr[DSP_LAT-1];
            r2_valid <= r1_valid;
        end
    end

    // Data registers carry no reset; their valid bits above decide whether they matter.
    always_ff @(posedge clk) begin
        if (vld_sr[DSP_LAT-1])
            r1_val <= round_shift(p, SHIFT);
        if (r1_valid) begin
            r2_data <= OUT_W'(saturate(r1_val, OUT_W));
            r2_sat  <= sat_hit(r1_val, OUT_W);
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r2_valid),
        .wr_data ({r2_sat, r2_data}),
        .rd_en   (out_ready),
        .rd_data (fifo_q),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .wr_ok   (fifo_wr_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop    <= 1'b0;
            sat_cnt <= '0;
        end else begin
            drop <= r2_valid && fifo_full && !(out_ready && !fifo_empty);
            if (fifo_wr_ok && r2_sat && (sat_cnt != 16'hFFFF))
                sat_cnt <= sat_cnt + 16'd1;
        end
    end

    // Masking with empty keeps out_data at zero whenever no word is presented.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_q[OUT_W-1:0];
    assign out_sat   = !fifo_empty && fifo_q[OUT_W];

endmodule

// File: tb/tb_dsp_out_stage.sv
// Scoreboard bench for dsp_out_stage: a behavioural model predicts each word, its buffer
// fate and its arrival; a negedge monitor compares every presented word against it.
module tb_dsp_out_stage;

    localparam int DSP_LAT    = 4;
    localparam int SHIFT      = 17;
    localparam int OUT_W      = 18;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        longint data;
        bit     sat;
        longint due;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic signed [47:0]       p;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;
    logic                     drop;
    logic [15:0]              sat_cnt;

    int     nChecks = 0;
    int     nPass   = 0;
    int     cyc     = 0;
    int     lastIssue;
    int     dropSeen;
    int     hsSeen;
    exp_t   pending[$];
    exp_t   modelq[$];
    bit     expDrop = 1'b0;
    longint expSatCnt = 0;
    logic signed [47:0] pline [DSP_LAT];

    dsp_out_stage #(
        .DSP_LAT    (DSP_LAT),
        .SHIFT      (SHIFT),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .p         (p),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .drop      (drop),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input longint act, input longint exp);
        nChecks++;
        if (act == exp)
            nPass++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference: round half up by floor division, then clamp to the output range.
    function automatic longint refRound(input longint v);
        longint d, s, q;
        d = longint'(1) << SHIFT;
        s = v + ((SHIFT > 0) ? d / 2 : 0);
        q = s / d;
        if ((s % d != 0) && (s < 0))
            q = q - 1;
        return q;
    endfunction

    function automatic longint refHi();
        return (longint'(1) << (OUT_W - 1)) - 1;
    endfunction

    function automatic bit refSat(input longint v);
        longint r;
        r = refRound(v);
        return (r > refHi()) || (r < -refHi() - 1);
    endfunction

    function automatic longint refData(input longint v);
        longint r;
        r = refRound(v);
        if (r > refHi())
            return refHi();
        if (r < -refHi() - 1)
            return -refHi() - 1;
        return r;
    endfunction

    function automatic logic signed [47:0] rnd48();
        return 48'({$urandom(), $urandom()});
    endfunction

    function automatic longint randP();
        logic signed [47:0] r;
        longint base;
        base = longint'(131071) * 131072;
        case ($urandom_range(0, 3))
            0: begin
                r = rnd48();
                return longint'(r >>> $urandom_range(0, 40));
            end
            1: return base + longint'($urandom_range(0, 262144)) - 131072;
            2: return -base - longint'($urandom_range(0, 262144)) + 131072 - 131072;
            default: return longint'(rnd48());
        endcase
    endfunction

    // Drives one cycle of inputs; the multiplier model returns p exactly DSP_LAT cycles later.
    task automatic applyStimulus(input bit iv, input longint val, input bit rdy);
        @(posedge clk);
        #2;
        in_valid  = iv;
        out_ready = rdy;
        p = pline[DSP_LAT-1];
        for (int i = DSP_LAT - 1; i > 0; i--)
            pline[i] = pline[i-1];
        pline[0] = iv ? 48'(val) : rnd48();
        if (iv) begin
            pending.push_back('{data: refData(val), sat: refSat(val), due: longint'(cyc + DSP_LAT + 3)});
            lastIssue = cyc;
        end
    endtask

    task automatic stepCount(input bit iv, input longint val, input bit rdy);
        applyStimulus(iv, val, rdy);
        @(negedge clk);
        if (drop)
            dropSeen++;
        if (out_valid && out_ready)
            hsSeen++;
    endtask

    task automatic expectWord(input string nm, input longint expData, input bit expSat, input bit chkLat);
        bit found;
        found = 1'b0;
        for (int k = 0; k < DSP_LAT + 12 && !found; k++) begin
            applyStimulus(1'b0, 0, 1'b1);
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                checkOutput({nm, "_data"}, longint'(out_data), expData);
                checkOutput({nm, "_sat"}, longint'(out_sat), longint'(expSat));
                if (chkLat)
                    checkOutput({nm, "_latency"}, longint'(cyc - (lastIssue + 1)), longint'(DSP_LAT + 2));
            end
        end
        checkOutput({nm, "_seen"}, longint'(found), 1);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        pending.delete();
        modelq.delete();
        expDrop   = 1'b0;
        expSatCnt = 0;
        @(negedge clk);
        checkOutput("rst_mid_out_valid", longint'(out_valid), 0);
        checkOutput("rst_mid_sat_cnt", longint'(sat_cnt), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT state with the model, then advance the model across the next edge.
    always @(negedge clk) begin
        exp_t e;
        checkOutput("out_valid", longint'(out_valid), longint'(modelq.size() > 0));
        if (modelq.size() > 0) begin
            checkOutput("out_data", longint'(out_data), modelq[0].data);
            checkOutput("out_sat", longint'(out_sat), longint'(modelq[0].sat));
        end
        checkOutput("drop", longint'(drop), longint'(expDrop));
        checkOutput("sat_cnt", longint'(sat_cnt), expSatCnt);
        expDrop = 1'b0;
        if (rst_n) begin
            if (out_ready && modelq.size() > 0)
                void'(modelq.pop_front());
            while (pending.size() > 0 && pending[0].due <= longint'(cyc + 1)) begin
                e = pending.pop_front();
                if (modelq.size() < FIFO_DEPTH) begin
                    modelq.push_back(e);
                    if (e.sat && expSatCnt < 65535)
                        expSatCnt++;
                end else begin
                    expDrop = 1'b1;
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p         = '0;
        for (int i = 0; i < DSP_LAT; i++)
            pline[i] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_data", longint'(out_data), 0);
        checkOutput("reset_out_sat", longint'(out_sat), 0);
        checkOutput("reset_drop", longint'(drop), 0);
        checkOutput("reset_sat_cnt", longint'(sat_cnt), 0);

        applyStimulus(1'b1, longint'(3) << 17, 1'b1);
        expectWord("basic", 3, 1'b0, 1'b1);

        applyStimulus(1'b1, (longint'(5) << 17) + (longint'(1) << 16), 1'b1);
        expectWord("round_up", 6, 1'b0, 1'b0);
        applyStimulus(1'b1, -(longint'(1) << 16), 1'b1);
        expectWord("round_neg_half", 0, 1'b0, 1'b0);
        applyStimulus(1'b1, -(longint'(1) << 16) - 1, 1'b1);
        expectWord("round_neg_below", -1, 1'b0, 1'b0);

        applyStimulus(1'b1, longint'(1) << 40, 1'b1);
        expectWord("sat_pos", 131071, 1'b1, 1'b0);
        applyStimulus(1'b1, -(longint'(1) << 40), 1'b1);
        expectWord("sat_neg", -131072, 1'b1, 1'b0);
        repeat (2) stepCount(1'b0, 0, 1'b1);
        checkOutput("sat_cnt_two", longint'(sat_cnt), 2);

        // Backpressure: five samples into a four-entry buffer.
        dropSeen = 0;
        for (int i = 0; i < 5; i++)
            stepCount(1'b1, longint'($urandom_range(0, 1 << 24)) - (1 << 23), 1'b0);
        repeat (DSP_LAT + 6) stepCount(1'b0, 0, 1'b0);
        checkOutput("bp_drop_count", dropSeen, 1);
        hsSeen = 0;
        repeat (10) stepCount(1'b0, 0, 1'b1);
        checkOutput("bp_drained", hsSeen, 4);

        // Full buffer sees a read and a write on the same edge.
        dropSeen = 0;
        for (int i = 0; i < 4; i++)
            stepCount(1'b1, longint'($urandom_range(0, 1 << 24)), 1'b0);
        stepCount(1'b0, 0, 1'b0);
        stepCount(1'b1, longint'($urandom_range(0, 1 << 24)), 1'b0);
        repeat (DSP_LAT + 1) stepCount(1'b0, 0, 1'b0);
        stepCount(1'b0, 0, 1'b1);
        repeat (DSP_LAT) stepCount(1'b0, 0, 1'b0);
        checkOutput("full_rw_drop", dropSeen, 0);
        hsSeen = 0;
        repeat (10) stepCount(1'b0, 0, 1'b1);
        checkOutput("full_rw_occupancy", hsSeen, 4);

        // Reset with two stored words and three samples still in the pipeline.
        stepCount(1'b1, longint'(1) << 40, 1'b0);
        stepCount(1'b1, -(longint'(1) << 40), 1'b0);
        repeat (DSP_LAT + 4) stepCount(1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++)
            stepCount(1'b1, longint'($urandom_range(0, 1 << 24)), 1'b0);
        pulseReset();
        hsSeen = 0;
        repeat (DSP_LAT + 12) stepCount(1'b0, 0, 1'b1);
        checkOutput("rst_no_stale", hsSeen, 0);

        for (int i = 0; i < 1500; i++)
            stepCount(1'($urandom_range(0, 1)), randP(), ($urandom_range(0, 3) != 0));
        repeat (DSP_LAT + 20) stepCount(1'b0, 0, 1'b1);
        checkOutput("final_idle", longint'(out_valid), 0);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
